multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: INSTR_W, default 32, instruction width in bits.
REQ-002 Parameter: OPC_W, default 5, opcode width; opcode = instruction[INSTR_W-1 -: OPC_W].
REQ-003 Parameter: ALUOP_W, default 4, alu_op width.
REQ-004 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: instruction  in  INSTR_W  fetched word; sampled only when ir_write is asserted.
REQ-008 Port: instr_valid  in  1  fetch data valid.
REQ-009 Port: mem_ready  in  1  data-memory access complete.
REQ-010 Port: alu_zero  in  1  ALU result equals zero.
REQ-011 Port: alu_gt  in  1  signed A>B from ALU.
REQ-012 Port: alu_op  out  ALUOP_W  ALU operation select.
REQ-013 Port: alu_src  out  1  ALU operand B source; 1 selects immediate.
REQ-014 Port: reg_write, mem_read, mem_write, mem_to_reg  out  1 each  datapath strobes.
REQ-015 Port: ir_write, pc_write  out  1 each  instruction-register load and PC update.
REQ-016 Port: pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = return address.
REQ-017 Port: link  out  1  CALL writes the return address.
REQ-018 Port: state  out  3  current FSM state, for debug.
REQ-019 Port: illegal_op  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-020 Opcode map, with its ALU op: ADD 00000/0000, SUB 00001/0001, MUL 00010/0010, DIV 00011/0011, MOD 00100/0100, CMP 00101/1011, AND 00110/0101, OR 00111/0110, NOT 01000/0111, MOV 01001/0000 (imm), LSL 01010/1000, LSR 01011/1001, ASR 01100/1010.
REQ-021 Remaining opcodes: NOP 01101, LD 01110, ST 01111, BEQ 10000, BGT 10001, B 10010, CALL 10011, RET 10100; all others are illegal.
REQ-022 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-023 FETCH: hold until instr_valid=1; in that cycle assert ir_write, latch the opcode, then go to DECODE.
REQ-024 DECODE: all strobes 0.
REQ-025 DECODE exits: NOP goes to FETCH with pc_write=1, pc_src=0; an illegal opcode does the same and also pulses illegal_op; all other opcodes go to EXEC.
REQ-026 EXEC: drive alu_op and alu_src per REQ-020; LD and ST use alu_op 0000 with alu_src=1; BEQ and BGT use 0001 with alu_src=0.
REQ-027 EXEC exits, ALU ops except CMP: go to WB.
REQ-028 EXEC exits, CMP: latch flag_eq<=alu_zero and flag_gt<=alu_gt; pc_write=1, pc_src=0; go to FETCH.
REQ-029 EXEC exits, LD and ST: go to MEM.
REQ-030 EXEC exits, BEQ and BGT: pc_write=1; pc_src=1 if (BEQ and flag_eq) or (BGT and flag_gt), else 0; go to FETCH.
REQ-031 EXEC exits, jumps: B gives pc_write=1, pc_src=2. CALL gives pc_write=1, pc_src=2, reg_write=1, link=1. RET gives pc_write=1, pc_src=3. All go to FETCH.
REQ-032 MEM: keep alu_op/alu_src as in EXEC; assert mem_read (LD) or mem_write (ST) every cycle until mem_ready=1.
REQ-033 MEM exits: on mem_ready, LD goes to WB; ST goes to FETCH with pc_write=1, pc_src=0.
REQ-034 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 only for LD; pc_write=1, pc_src=0; go to FETCH.
REQ-035 Strobes are Moore/Mealy combinational from the state and the latched opcode; each strobe is 0 in any state not listed for it.
REQ-036 Latency: ALU op 4 cycles and CMP 3 cycles, from the instr_valid cycle to the next FETCH, with zero wait states.
REQ-037 Latency: LD 5+W cycles and ST 4+W cycles, where W is the number of mem_ready-low cycles in MEM.
REQ-038 Flags change only in CMP EXEC; BEQ/BGT use the last latched flags.
REQ-039 Only one pc_write pulse per instruction.
REQ-040 instruction changing outside the ir_write cycle has no effect.
REQ-041 mem_ready=1 in any state other than MEM is ignored.

Reset
REQ-042 While rst=1 at a rising clk: state<=FETCH, opcode<=NOP, flag_eq<=0, flag_gt<=0.
REQ-043 During reset every output is 0, except state which reads 0.
REQ-044 rst asserted in any state, including mid-MEM wait, aborts the instruction with no further strobes.
REQ-045 After reset, FETCH resumes on the first cycle with rst=0.

Verification
REQ-046 ADD (0x00000000) with instr_valid and mem_ready=1: ir_write at cycle 0, alu_op=0000 at cycle 2, reg_write=1 with pc_write=1/pc_src=0 at cycle 3, state=0 at cycle 4.
REQ-047 LD with mem_ready low for 3 cycles: mem_read=1 for 4 cycles in MEM, then WB with reg_write=1 and mem_to_reg=1; mem_write stays 0.
REQ-048 CMP with alu_zero=1, then BEQ: pc_src=1 in BEQ EXEC.
REQ-049 CMP with alu_zero=0, alu_gt=1, then BEQ: pc_src=0. A following BGT: pc_src=1.
REQ-050 CALL gives reg_write=1, link=1, pc_src=2 in one cycle. RET gives pc_src=3 with reg_write=0.
REQ-051 Opcode 11111: illegal_op pulses for 1 cycle in DECODE, then FETCH with pc_write=1. rst asserted in MEM during an ST wait: next cycle all outputs are 0 and state=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle processor control unit.
// A five-state FSM (FETCH, DECODE, EXEC, MEM, WB) sequences each instruction.
// The datapath strobes are decoded combinationally from the current state,
// the latched opcode, the latched compare flags and a few live inputs.
// While rst is high every output, including the state readback, is forced to 0.

module multicycle_control_unit #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_gt,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               link,
  output logic [2:0]         state,
  output logic               illegal_op
);

  // Opcode map. Everything numerically above RET is undefined.
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MOD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_CMP  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_LSR  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_ASR  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_B    = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(20);

  // ALU operation codes.
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_DIV = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_MOD = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOT = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_LSL = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_LSR = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_ASR = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_CMP = ALUOP_W'(11);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           r_state;
  logic [OPC_W-1:0] r_opcode;
  logic             r_flag_eq;
  logic             r_flag_gt;

  logic               w_is_alu;
  logic               w_is_cmp;
  logic               w_is_nop;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_is_beq;
  logic               w_is_bgt;
  logic               w_is_b;
  logic               w_is_call;
  logic               w_is_ret;
  logic               w_is_illegal;
  logic               w_branch_taken;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_alu_src;
  logic               w_unused_instr_bits;

  // Only the opcode field of the instruction word matters to control.
  assign w_unused_instr_bits = &{1'b0, instruction[INSTR_W-OPC_W-1:0]};

  // Instruction classes from the latched opcode.
  assign w_is_alu     = (r_opcode <= OP_ASR) && (r_opcode != OP_CMP);
  assign w_is_cmp     = (r_opcode == OP_CMP);
  assign w_is_nop     = (r_opcode == OP_NOP);
  assign w_is_ld      = (r_opcode == OP_LD);
  assign w_is_st      = (r_opcode == OP_ST);
  assign w_is_beq     = (r_opcode == OP_BEQ);
  assign w_is_bgt     = (r_opcode == OP_BGT);
  assign w_is_b       = (r_opcode == OP_B);
  assign w_is_call    = (r_opcode == OP_CALL);
  assign w_is_ret     = (r_opcode == OP_RET);
  assign w_is_illegal = (r_opcode > OP_RET);

  // Conditional branches consult the flags captured by the most recent CMP.
  assign w_branch_taken = (w_is_beq && r_flag_eq) || (w_is_bgt && r_flag_gt);

  // ALU operation and operand-B source used during EXEC and MEM.
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b0;
    case (r_opcode)
      OP_ADD:         w_alu_op = ALU_ADD;
      OP_SUB:         w_alu_op = ALU_SUB;
      OP_MUL:         w_alu_op = ALU_MUL;
      OP_DIV:         w_alu_op = ALU_DIV;
      OP_MOD:         w_alu_op = ALU_MOD;
      OP_CMP:         w_alu_op = ALU_CMP;
      OP_AND:         w_alu_op = ALU_AND;
      OP_OR:          w_alu_op = ALU_OR;
      OP_NOT:         w_alu_op = ALU_NOT;
      OP_MOV: begin
        w_alu_op  = ALU_ADD;
        w_alu_src = 1'b1;
      end
      OP_LSL:         w_alu_op = ALU_LSL;
      OP_LSR:         w_alu_op = ALU_LSR;
      OP_ASR:         w_alu_op = ALU_ASR;
      OP_LD, OP_ST: begin
        // Address generation: base register plus immediate offset.
        w_alu_op  = ALU_ADD;
        w_alu_src = 1'b1;
      end
      OP_BEQ, OP_BGT: w_alu_op = ALU_SUB;
      default: begin
        w_alu_op  = ALU_ADD;
        w_alu_src = 1'b0;
      end
    endcase
  end

  // State sequencing plus opcode and flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= OP_NOP;
      r_flag_eq <= 1'b0;
      r_flag_gt <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_opcode <= instruction[INSTR_W-1 -: OPC_W];
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_is_nop || w_is_illegal) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_cmp) begin
            r_flag_eq <= alu_zero;
            r_flag_gt <= alu_gt;
            r_state   <= S_FETCH;
          end else if (w_is_alu) begin
            r_state <= S_WB;
          end else if (w_is_ld || w_is_st) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= w_is_ld ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath strobes; everything is held at 0 while reset is asserted.
  always_comb begin
    alu_op     = '0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    link       = 1'b0;
    state      = 3'd0;
    illegal_op = 1'b0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          ir_write = instr_valid;
        end
        S_DECODE: begin
          // NOP and undefined opcodes retire straight from DECODE.
          if (w_is_nop || w_is_illegal) begin
            pc_write   = 1'b1;
            illegal_op = w_is_illegal;
          end
        end
        S_EXEC: begin
          alu_op  = w_alu_op;
          alu_src = w_alu_src;
          if (w_is_cmp) begin
            pc_write = 1'b1;
          end
          if (w_is_beq || w_is_bgt) begin
            pc_write = 1'b1;
            pc_src   = w_branch_taken ? 2'd1 : 2'd0;
          end
          if (w_is_b) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          if (w_is_call) begin
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            reg_write = 1'b1;
            link      = 1'b1;
          end
          if (w_is_ret) begin
            pc_write = 1'b1;
            pc_src   = 2'd3;
          end
        end
        S_MEM: begin
          // Address stays stable and the request is held until memory acknowledges.
          alu_op    = w_alu_op;
          alu_src   = w_alu_src;
          mem_read  = w_is_ld;
          mem_write = w_is_st;
          if (w_is_st && mem_ready) begin
            pc_write = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = w_is_ld;
          pc_write   = 1'b1;
        end
        default: begin
          state = r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Each instruction is expanded by a class-level reference model into its
// expected per-cycle output bundle; random opcodes, fetch gaps, memory wait
// states and ALU flag inputs exercise the FSM, plus directed reset cases.

module tb_multicycle_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_ready;
  logic        alu_zero;
  logic        alu_gt;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        link;
  logic [2:0]  state;
  logic        illegal_op;

  typedef struct packed {
    logic       ill;
    logic [2:0] st;
    logic       lnk;
    logic [1:0] pcs;
    logic       pcw;
    logic       irw;
    logic       m2r;
    logic       mw;
    logic       mr;
    logic       rw;
    logic       asrc;
    logic [3:0] aop;
  } outs_t;

  int n_checks = 0;
  int n_errors = 0;
  int n_instr  = 0;

  // Reference flag state (last CMP result, cleared by reset).
  logic m_eq = 1'b0;
  logic m_gt = 1'b0;

  // ALU op per opcode 0..12.
  logic [3:0] aluop_tbl [0:12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd5,
                                   4'd6, 4'd7, 4'd0, 4'd8, 4'd9, 4'd10};

  multicycle_control_unit #(
    .INSTR_W(32),
    .OPC_W(5),
    .ALUOP_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .mem_ready(mem_ready),
    .alu_zero(alu_zero),
    .alu_gt(alu_gt),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .link(link),
    .state(state),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, advance past the edge.
  task automatic cycle(input outs_t exp, input logic iv, input logic [31:0] instr,
                       input logic mr, input logic az, input logic ag, input string tag);
    outs_t got;
    instr_valid = iv;
    instruction = instr;
    mem_ready   = mr;
    alu_zero    = az;
    alu_gt      = ag;
    @(negedge clk);
    got = {illegal_op, state, link, pc_src, pc_write, ir_write, mem_to_reg,
           mem_write, mem_read, reg_write, alu_src, alu_op};
    check(tag, {14'd0, got}, {14'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // Run one complete instruction through the reference model.
  task automatic run_instr(input logic [4:0] opc, input int w, input int idle,
                           input logic cz, input logic cg);
    outs_t e;
    string tag;
    n_instr++;
    $display("instr %0d: opcode %0d wait %0d idle %0d zero %0b gt %0b flags eq %0b gt %0b",
             n_instr, opc, w, idle, cz, cg, m_eq, m_gt);
    // Idle FETCH cycles: garbage on instruction and mem_ready must be ignored.
    for (int i = 0; i < idle; i++) begin
      e = '0;
      tag = $sformatf("i%0d_op%0d_fetchwait", n_instr, opc);
      cycle(e, 1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), tag);
    end
    // Fetch cycle.
    e = '0;
    e.irw = 1'b1;
    tag = $sformatf("i%0d_op%0d_fetch", n_instr, opc);
    cycle(e, 1'b1, {opc, 27'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom), tag);
    // Decode cycle.
    e = '0;
    e.st = 3'd1;
    if (opc == 5'd13) e.pcw = 1'b1;
    if (opc > 5'd20) begin
      e.pcw = 1'b1;
      e.ill = 1'b1;
    end
    tag = $sformatf("i%0d_op%0d_decode", n_instr, opc);
    cycle(e, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), tag);
    if (opc == 5'd13 || opc > 5'd20) return;
    // Execute cycle.
    e = '0;
    e.st = 3'd2;
    if (opc <= 5'd12) begin
      e.aop  = aluop_tbl[opc];
      e.asrc = (opc == 5'd9);
      if (opc == 5'd5) e.pcw = 1'b1;
    end else if (opc == 5'd14 || opc == 5'd15) begin
      e.aop  = 4'd0;
      e.asrc = 1'b1;
    end else if (opc == 5'd16) begin
      e.aop = 4'd1;
      e.pcw = 1'b1;
      e.pcs = m_eq ? 2'd1 : 2'd0;
    end else if (opc == 5'd17) begin
      e.aop = 4'd1;
      e.pcw = 1'b1;
      e.pcs = m_gt ? 2'd1 : 2'd0;
    end else if (opc == 5'd18) begin
      e.pcw = 1'b1;
      e.pcs = 2'd2;
    end else if (opc == 5'd19) begin
      e.pcw = 1'b1;
      e.pcs = 2'd2;
      e.rw  = 1'b1;
      e.lnk = 1'b1;
    end else begin
      e.pcw = 1'b1;
      e.pcs = 2'd3;
    end
    tag = $sformatf("i%0d_op%0d_exec", n_instr, opc);
    cycle(e, 1'($urandom), $urandom, 1'($urandom), cz, cg, tag);
    if (opc == 5'd5) begin
      m_eq = cz;
      m_gt = cg;
    end
    // Memory cycles: request held through w not-ready cycles plus the ready one.
    if (opc == 5'd14 || opc == 5'd15) begin
      for (int k = 0; k <= w; k++) begin
        e = '0;
        e.st   = 3'd3;
        e.asrc = 1'b1;
        e.mr   = (opc == 5'd14);
        e.mw   = (opc == 5'd15);
        if (opc == 5'd15 && k == w) e.pcw = 1'b1;
        tag = $sformatf("i%0d_op%0d_mem%0d", n_instr, opc, k);
        cycle(e, 1'($urandom), $urandom, (k == w), 1'($urandom), 1'($urandom), tag);
      end
    end
    // Write-back cycle for ALU ops and loads.
    if ((opc <= 5'd12 && opc != 5'd5) || opc == 5'd14) begin
      e = '0;
      e.st  = 3'd4;
      e.rw  = 1'b1;
      e.m2r = (opc == 5'd14);
      e.pcw = 1'b1;
      tag = $sformatf("i%0d_op%0d_wb", n_instr, opc);
      cycle(e, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), tag);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t z;
    int    r;
    logic [4:0] opc;
    z = '0;
    rst = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    alu_gt = 1'b0;
    @(posedge clk);
    #1;
    // Outputs stay 0 under reset even with active-looking inputs.
    cycle(z, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, "reset_hold0");
    cycle(z, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "reset_hold1");
    rst = 1'b0;
    m_eq = 1'b0;
    m_gt = 1'b0;

    // Directed scenarios.
    run_instr(5'd0, 0, 0, 1'b0, 1'b0);   // ADD
    run_instr(5'd14, 3, 0, 1'b0, 1'b0);  // LD with 3 wait states
    run_instr(5'd5, 0, 0, 1'b1, 1'b0);   // CMP equal
    run_instr(5'd16, 0, 0, 1'b0, 1'b0);  // BEQ taken
    run_instr(5'd5, 0, 1, 1'b0, 1'b1);   // CMP greater
    run_instr(5'd16, 0, 0, 1'b0, 1'b0);  // BEQ not taken
    run_instr(5'd17, 0, 0, 1'b0, 1'b0);  // BGT taken
    run_instr(5'd19, 0, 0, 1'b0, 1'b0);  // CALL
    run_instr(5'd20, 0, 0, 1'b0, 1'b0);  // RET
    run_instr(5'd31, 0, 0, 1'b0, 1'b0);  // illegal
    run_instr(5'd13, 0, 2, 1'b0, 1'b0);  // NOP
    run_instr(5'd15, 2, 0, 1'b0, 1'b0);  // ST with 2 wait states
    run_instr(5'd5, 0, 0, 1'b1, 1'b1);   // CMP sets both flags

    // ST aborted by reset during its memory wait.
    begin
      outs_t e;
      n_instr++;
      $display("instr %0d: ST aborted by reset in MEM", n_instr);
      e = '0; e.irw = 1'b1;
      cycle(e, 1'b1, {5'd15, 27'd0}, 1'b0, 1'b0, 1'b0, "abort_fetch");
      e = '0; e.st = 3'd1;
      cycle(e, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "abort_decode");
      e = '0; e.st = 3'd2; e.asrc = 1'b1;
      cycle(e, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "abort_exec");
      e = '0; e.st = 3'd3; e.asrc = 1'b1; e.mw = 1'b1;
      cycle(e, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "abort_mem0");
      rst = 1'b1;
      cycle(z, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1, "abort_in_reset");
      rst = 1'b0;
      m_eq = 1'b0;
      m_gt = 1'b0;
      cycle(z, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, "abort_after_reset");
    end
    // Flags were cleared by reset: neither branch is taken.
    run_instr(5'd16, 0, 0, 1'b0, 1'b0);
    run_instr(5'd17, 0, 0, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 24));
      if (r > 20) opc = 5'($urandom_range(21, 31));
      else        opc = 5'(r);
      run_instr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
